// File: rtl/mips_timer_pkg.sv
// Shared definitions for the memory-mapped timer: FSM encodings, register
// offsets, mode codes and CTRL bit positions.
package mips_timer_pkg;

    typedef enum logic [1:0] {
        TIMER_IDLE = 2'd0,
        TIMER_LOAD = 2'd1,
        TIMER_CNT  = 2'd2,
        TIMER_INT  = 2'd3
    } timer_state_e;

    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Only 01 auto-reloads; 1x falls back to one-shot.
    function automatic logic is_reload(input logic [3:0] ctrl);
        return ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/mips_timer_tick.sv
// Prescaler tick generator: counts 0..PRESCALE-1 while run is high and
// flags the last cycle of each window; restart returns it to 0.
module mips_timer_tick #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic tick
);

    logic [31:0] cnt;

    assign tick = (cnt == 32'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 32'd0;
        end else if (restart) begin
            cnt <= 32'd0;
        end else if (run) begin
            cnt <= tick ? 32'd0 : cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped down-counter timer feeding CP0 HWInt[0]; one-shot or
// auto-reload. Define TIMER_PRESCALE_EN to divide the count rate by PRESCALE.
module mips_timer
    import mips_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    timer_state_e state, state_next;
    logic [3:0]   ctrl, ctrl_next;
    logic [31:0]  preset, preset_next;
    logic [31:0]  count, count_next;
    logic         irq_flag, flag_next;
    logic         tick, tick_restart, tick_run;
    logic         ctrl_wr, preset_wr;
    logic         unused_addr;

    assign unused_addr = ^{addr[31:4], addr[1:0]};
    assign ctrl_wr     = we && (addr[3:2] == TIMER_CTRL);
    assign preset_wr   = we && (addr[3:2] == TIMER_PRESET);

`ifdef TIMER_PRESCALE_EN
    mips_timer_tick #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(tick_restart),
        .run    (tick_run),
        .tick   (tick)
    );
`else
    logic unused_tick;
    assign unused_tick = tick_restart ^ tick_run;
    // Without a prescaler every CNT cycle is a tick (PRESCALE >= 1 always holds).
    assign tick = (PRESCALE >= 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= TIMER_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_next;
            ctrl     <= ctrl_next;
            preset   <= preset_next;
            count    <= count_next;
            irq_flag <= flag_next;
        end
    end

    always_comb begin
        state_next   = state;
        ctrl_next    = ctrl;
        preset_next  = preset;
        count_next   = count;
        flag_next    = irq_flag;
        tick_restart = 1'b0;
        tick_run     = 1'b0;
        // A CPU write to CTRL/PRESET overrides the FSM step; COUNT holds.
        if (ctrl_wr || preset_wr) begin
            if (ctrl_wr)   ctrl_next   = din[3:0];
            if (preset_wr) preset_next = din;
            state_next = TIMER_IDLE;
            flag_next  = 1'b0;
        end else begin
            case (state)
                TIMER_IDLE: begin
                    if (ctrl[CTRL_EN]) state_next = TIMER_LOAD;
                end
                TIMER_LOAD: begin
                    count_next   = preset;
                    tick_restart = 1'b1;
                    state_next   = TIMER_CNT;
                end
                TIMER_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state_next = TIMER_IDLE;
                    end else begin
                        tick_run = 1'b1;
                        if (tick) begin
                            // <= 1 rather than == 1 so PRESET=0 never wraps.
                            if (count <= 32'd1) begin
                                count_next = 32'd0;
                                flag_next  = 1'b1;
                                state_next = TIMER_INT;
                            end else begin
                                count_next = count - 32'd1;
                            end
                        end
                    end
                end
                TIMER_INT: begin
                    if (is_reload(ctrl)) begin
                        flag_next  = 1'b0;
                        state_next = TIMER_LOAD;
                    end else begin
                        ctrl_next[CTRL_EN] = 1'b0;
                        state_next         = TIMER_IDLE;
                    end
                end
                default: state_next = TIMER_IDLE;
            endcase
        end
    end

    always_comb begin
        case (addr[3:2])
            TIMER_CTRL:   dout = {28'd0, ctrl};
            TIMER_PRESET: dout = preset;
            TIMER_COUNT:  dout = count;
            default:      dout = 32'd0;
        endcase
    end

    assign irq = ctrl[CTRL_IM] & irq_flag;

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: one-shot, auto-reload, mask, pause,
// boundary cases and asynchronous reset, with hand-computed expectations.
module tb_mips_timer;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mips_timer #(.PRESCALE(4)) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, dout, exp);
    endtask

    task automatic irq_check(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    logic [31:0] reload_cnt[5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

    initial begin
        reset = 1'b1;
        addr  = 32'd0;
        we    = 1'b0;
        din   = 32'd0;
        #12;
        irq_check("rst_irq", 1'b0);
        read_check("rst_ctrl", 32'h0, 32'd0);
        read_check("rst_count", 32'h8, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // One-shot, PRESET=5: irq rises after E7, EN self-clears.
        bus_write(32'h4, 32'd5);
        bus_write(32'h0, 32'h9);
        read_check("os_count_hold", 32'h8, 32'd0);
        step(1);
        read_check("os_load", 32'h8, 32'd0);
        step(1);
        read_check("os_e2", 32'h8, 32'd5);
        irq_check("os_e2_irq", 1'b0);
        step(4);
        read_check("os_e6", 32'h8, 32'd1);
        irq_check("os_e6_irq", 1'b0);
        step(1);
        irq_check("os_e7_irq", 1'b1);
        read_check("os_e7_count", 32'h8, 32'd0);
        read_check("os_e7_ctrl", 32'h0, 32'h9);
        step(1);
        read_check("os_e8_ctrl", 32'h0, 32'h8);
        irq_check("os_e8_irq", 1'b1);
        step(3);
        irq_check("os_hold_irq", 1'b1);
        bus_write(32'h0, 32'h8);
        irq_check("os_clear_irq", 1'b0);

        // Auto-reload, PRESET=3: 1-cycle pulse every 5 cycles.
        bus_write(32'h4, 32'd3);
        bus_write(32'h0, 32'hB);
        irq_check("ar_e0_irq", 1'b0);
        step(2);
        for (int k = 2; k <= 16; k++) begin
            check($sformatf("ar_count_e%0d", k), dut.count, reload_cnt[(k - 2) % 5]);
            irq_check($sformatf("ar_irq_e%0d", k), ((k - 2) % 5) == 3);
            if (k < 16) step(1);
        end
        bus_write(32'h8, 32'h55);
        read_check("count_wr_ignored", 32'h8, 32'd3);
        read_check("ar_ctrl", 32'h0, 32'hB);
        read_check("read_0xc", 32'hC, 32'd0);

        // IM=0 one-shot: counts to 0, irq stays low; CTRL write drops the flag.
        bus_write(32'h0, 32'h0);
        bus_write(32'h4, 32'd4);
        bus_write(32'h0, 32'h1);
        step(6);
        read_check("mask_count0", 32'h8, 32'd0);
        irq_check("mask_irq", 1'b0);
        step(3);
        irq_check("mask_irq_late", 1'b0);
        read_check("mask_ctrl", 32'h0, 32'h0);
        bus_write(32'h0, 32'h8);
        irq_check("mask_im_set", 1'b0);
        step(2);
        irq_check("mask_im_later", 1'b0);

        // Pause at COUNT=2, then re-enable reloads PRESET.
        bus_write(32'h4, 32'd6);
        bus_write(32'h0, 32'h9);
        step(6);
        read_check("pause_pre", 32'h8, 32'd2);
        bus_write(32'h0, 32'h8);
        read_check("pause_hold", 32'h8, 32'd2);
        step(3);
        read_check("pause_hold3", 32'h8, 32'd2);
        irq_check("pause_irq", 1'b0);
        bus_write(32'h0, 32'h9);
        read_check("reen_e0", 32'h8, 32'd2);
        step(1);
        read_check("reen_e1", 32'h8, 32'd2);
        step(1);
        read_check("reen_e2", 32'h8, 32'd6);

        // PRESET=0 behaves as 1.
        bus_write(32'h0, 32'h0);
        bus_write(32'h4, 32'd0);
        bus_write(32'h0, 32'h9);
        step(2);
        read_check("p0_e2", 32'h8, 32'd0);
        irq_check("p0_e2_irq", 1'b0);
        step(1);
        irq_check("p0_e3_irq", 1'b1);
        // Write at the INT edge wins: flag cleared, EN kept.
        bus_write(32'h4, 32'd10);
        irq_check("pwr_irq_clear", 1'b0);
        read_check("pwr_ctrl", 32'h0, 32'h9);
        read_check("pwr_preset", 32'h4, 32'd10);
        step(4);
        read_check("cnt_g4", 32'h8, 32'd8);
        bus_write(32'h4, 32'd7);
        read_check("pwr_cnt_hold", 32'h8, 32'd8);
        irq_check("pwr_cnt_irq", 1'b0);
        step(1);
        read_check("pwr_load", 32'h8, 32'd8);
        step(1);
        read_check("pwr_reload", 32'h8, 32'd7);

        // Asynchronous reset mid-count.
        bus_write(32'h0, 32'hB);
        step(5);
        read_check("pre_reset_count", 32'h8, 32'd4);
        reset = 1'b1;
        #1;
        irq_check("arst_irq", 1'b0);
        check("arst_count", dut.count, 32'd0);
        step(1);
        read_check("arst_ctrl", 32'h0, 32'd0);
        read_check("arst_preset", 32'h4, 32'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef TIMER_PRESCALE_EN
        // PRESET=2, PRESCALE=4 auto-reload: INT at E10 and E20.
        bus_write(32'h4, 32'd2);
        bus_write(32'h0, 32'hB);
        step(9);
        irq_check("ps_e9", 1'b0);
        step(1);
        irq_check("ps_e10", 1'b1);
        step(1);
        irq_check("ps_e11", 1'b0);
        step(8);
        irq_check("ps_e19", 1'b0);
        step(1);
        irq_check("ps_e20", 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
